// File: rtl/adler32_par.sv
// Adler-32 engine folding BYTE_NUM bytes per clock, seedable, partial last beat.
// Latency: beat accepted at edge T -> dat_o/val_o (and done_o on last) in T+1.
// Backpressure: rdy_o high only while a stream is active; no stall inside a stream.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   start_i, seed_i   (re)start a checksum from {s2,s1} = seed_i
//   val_i, rdy_o      beat handshake
//   dat_i             BYTE_NUM bytes, byte 0 in the MSBs
//   lst_i, cnt_i      last beat marker, valid byte count on the last beat
//   val_o, done_o     beat-updated pulse, final-checksum pulse
//   dat_o             registered {s2, s1}
module adler32_par #(
    parameter int BYTE_NUM = 4,
    parameter int CNT_WD   = $clog2(BYTE_NUM) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [31:0]           seed_i,
    input  logic                  val_i,
    output logic                  rdy_o,
    input  logic [8*BYTE_NUM-1:0] dat_i,
    input  logic                  lst_i,
    input  logic [CNT_WD-1:0]     cnt_i,
    output logic                  val_o,
    output logic                  done_o,
    output logic [31:0]           dat_o
);

    localparam logic [CNT_WD-1:0] BN_C = CNT_WD'(BYTE_NUM);

    typedef enum logic {
        IDLE = 1'b0,
        ACTV = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_s1;
    logic [15:0]       r_s2;
    logic              r_val;
    logic              r_done;

    logic              w_rdy;
    logic              w_acc;
    logic [CNT_WD-1:0] w_k;
    logic [19:0]       w_byte;
    logic [19:0]       w_dsum;
    logic [19:0]       w_wsum;
    logic [16:0]       w_sum1;
    logic [19:0]       w_sum2;
    logic [15:0]       w_s1_nxt;
    logic [15:0]       w_s2_nxt;

    // A seed half may lie anywhere in 0..65535; one subtract brings it into range.
    function automatic logic [15:0] seed_red(input logic [15:0] x);
        return (x >= 16'd65521) ? 16'(x - 16'd65521) : x;
    endfunction

    // FSM next state and ready. A start always wins over a same-cycle beat.
    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_state_nxt = ACTV;
            end
            ACTV: begin
                w_rdy = 1'b1;
                if (!start_i && val_i && lst_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign rdy_o = w_rdy;
    assign w_acc = val_i && w_rdy && !start_i;

    // Active byte count: full beat unless last, where cnt_i is clamped to BYTE_NUM.
    always_comb begin
        w_k = BN_C;
        if (lst_i) w_k = (cnt_i > BN_C) ? BN_C : cnt_i;
    end

    // Unrolled Adler recurrence: byte i is summed into s2 (k-i) times.
    always_comb begin
        w_byte = '0;
        w_dsum = '0;
        w_wsum = '0;
        for (int i = 0; i < BYTE_NUM; i++) begin
            w_byte = {12'd0, dat_i[8*(BYTE_NUM-i)-1 -: 8]};
            if (20'(i) < 20'(w_k)) begin
                w_dsum = w_dsum + w_byte;
                w_wsum = w_wsum + (20'(w_k) - 20'(i)) * w_byte;
            end
        end
        w_sum1 = 17'(w_dsum) + {1'b0, r_s1};
        w_sum2 = w_wsum + {4'd0, r_s2} + 20'(w_k) * {4'd0, r_s1};
    end

    // Modular reduction without a divider: s1 needs one subtract, s2 picks the
    // largest multiple of 65521 not above the sum (at most BYTE_NUM+1 of them).
    always_comb begin
        w_s1_nxt = (w_sum1 >= 17'd65521) ? 16'(w_sum1 - 17'd65521) : w_sum1[15:0];
        w_s2_nxt = w_sum2[15:0];
        for (int j = 1; j <= BYTE_NUM + 1; j++) begin
            if (w_sum2 >= 20'(j * 65521)) w_s2_nxt = 16'(w_sum2 - 20'(j * 65521));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_val  <= 1'b0;
            r_done <= 1'b0;
        end else if (start_i) begin
            r_s1   <= seed_red(seed_i[15:0]);
            r_s2   <= seed_red(seed_i[31:16]);
            r_val  <= 1'b0;
            r_done <= 1'b0;
        end else if (w_acc) begin
            r_s1   <= w_s1_nxt;
            r_s2   <= w_s2_nxt;
            r_val  <= 1'b1;
            r_done <= lst_i;
        end else begin
            r_val  <= 1'b0;
            r_done <= 1'b0;
        end
    end

    assign val_o  = r_val;
    assign done_o = r_done;
    assign dat_o  = {r_s2, r_s1};

endmodule

// File: tb/tb_adler32_par.sv
// Bench for adler32_par: directed stream table at BYTE_NUM=4 plus corner
// sequences, then parallel 0xFF stress streams at BYTE_NUM = 1, 2, 4, 8.
`timescale 1ns/1ps
module tb_adler32_par;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-serial reference: the textbook Adler-32 step.
    function automatic logic [31:0] mdl_byte(input logic [31:0] st, input logic [7:0] d);
        int s1;
        int s2;
        s1 = (int'(st[15:0]) + int'(d)) % 65521;
        s2 = (int'(st[31:16]) + s1) % 65521;
        return {s2[15:0], s1[15:0]};
    endfunction

    function automatic logic [31:0] mdl_seed(input logic [31:0] sd);
        int a;
        int b;
        a = int'(sd[15:0]) % 65521;
        b = int'(sd[31:16]) % 65521;
        return {b[15:0], a[15:0]};
    endfunction

    typedef struct packed {
        logic [31:0] dat;
        logic        done;
    } exp_t;

    // ---------------- main DUT (BYTE_NUM = 4) ----------------
    logic        start_i = 1'b0;
    logic [31:0] seed_i  = '0;
    logic        val_i   = 1'b0;
    logic [31:0] dat_i   = '0;
    logic        lst_i   = 1'b0;
    logic [2:0]  cnt_i   = '0;
    logic        rdy_o;
    logic        val_o;
    logic        done_o;
    logic [31:0] dat_o;

    adler32_par #(.BYTE_NUM(4)) u_dut (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (start_i),
        .seed_i  (seed_i),
        .val_i   (val_i),
        .rdy_o   (rdy_o),
        .dat_i   (dat_i),
        .lst_i   (lst_i),
        .cnt_i   (cnt_i),
        .val_o   (val_o),
        .done_o  (done_o),
        .dat_o   (dat_o)
    );

    exp_t        q[$];
    exp_t        m_e;
    logic [31:0] m_st   = '0;
    logic        m_actv = 1'b0;
    int          m_k;
    int          vo_run = 0;

    // Scoreboard producer: model follows the accepted beats itself.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_st   = '0;
            m_actv = 1'b0;
            q.delete();
        end else if (start_i) begin
            m_st   = mdl_seed(seed_i);
            m_actv = 1'b1;
        end else if (val_i && m_actv) begin
            m_k = lst_i ? ((cnt_i > 3'd4) ? 4 : int'(cnt_i)) : 4;
            for (int i = 0; i < m_k; i++) m_st = mdl_byte(m_st, dat_i[31-8*i -: 8]);
            q.push_back({m_st, lst_i});
            if (lst_i) m_actv = 1'b0;
        end
    end

    // Scoreboard consumer and per-cycle state checks.
    always @(negedge clk) begin
        if (rstn) begin
            chk("rdy_o", 32'(rdy_o), 32'(m_actv));
            chk("dat_o state", dat_o, m_st);
            chk("done_o without val_o", 32'(done_o & ~val_o), 32'd0);
            if (val_o) begin
                vo_run++;
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected val_o: dat_o %h, none expected", dat_o);
                end else begin
                    m_e = q.pop_front();
                    chk("beat dat_o", dat_o, m_e.dat);
                    chk("beat done_o", 32'(done_o), 32'(m_e.done));
                end
            end else begin
                vo_run = 0;
            end
        end
    end

    task automatic wait_done(output logic [31:0] fin, output int run);
        fin = '0;
        run = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (done_o) begin
                fin = dat_o;
                run = vo_run;
                break;
            end
        end
        if (run < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_o timeout: got none expected pulse within 10 cycles");
        end
    endtask

    task automatic do_start(input logic [31:0] sd);
        start_i = 1'b1;
        seed_i  = sd;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("start rdy_o", 32'(rdy_o), 32'd1);
        chk("start dat_o", dat_o, mdl_seed(sd));
    endtask

    // Sends n bytes back-to-back; lanes beyond the valid bytes carry 0xA5.
    task automatic run_stream(input logic [31:0] sd, input logic [95:0] d, input int n,
                              output logic [31:0] fin, output int nb, output int run);
        int          idx;
        logic [31:0] w;
        do_start(sd);
        nb  = (n == 0) ? 1 : (n + 3) / 4;
        idx = 0;
        for (int b = 0; b < nb; b++) begin
            w = 32'hA5A5_A5A5;
            for (int j = 0; j < 4; j++) begin
                if (idx + j < n) w[31-8*j -: 8] = d[8*(n-idx-j)-1 -: 8];
            end
            val_i = 1'b1;
            dat_i = w;
            lst_i = (b == nb - 1);
            cnt_i = (b == nb - 1) ? 3'(n - idx) : 3'd4;
            idx += 4;
            @(posedge clk);
            #1;
        end
        val_i = 1'b0;
        lst_i = 1'b0;
        wait_done(fin, run);
    endtask

    typedef struct {
        logic [31:0] seed;
        logic [95:0] data;
        int          n;
        logic [31:0] exp;
    } vec_t;

    // ---------------- stress instances ----------------
    logic go_stress = 1'b0;

    for (genvar gi = 0; gi < 4; gi++) begin : g_st
        localparam int BN = 1 << gi;
        localparam int CW = $clog2(BN) + 1;
        logic            s_start = 1'b0;
        logic            s_val   = 1'b0;
        logic            s_lst   = 1'b0;
        logic [8*BN-1:0] s_dat   = '1;
        logic [CW-1:0]   s_cnt   = CW'(BN);
        logic            s_rdy;
        logic            s_vo;
        logic            s_done;
        logic [31:0]     s_dato;
        logic [31:0]     s_m   = '0;
        logic            s_act = 1'b0;
        logic            fin   = 1'b0;
        exp_t            s_q[$];
        exp_t            s_e;

        adler32_par #(.BYTE_NUM(BN)) u_dut (
            .clk     (clk),
            .rstn    (rstn),
            .start_i (s_start),
            .seed_i  (32'h0000_0001),
            .val_i   (s_val),
            .rdy_o   (s_rdy),
            .dat_i   (s_dat),
            .lst_i   (s_lst),
            .cnt_i   (s_cnt),
            .val_o   (s_vo),
            .done_o  (s_done),
            .dat_o   (s_dato)
        );

        always @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                s_m   = '0;
                s_act = 1'b0;
                s_q.delete();
            end else if (s_start) begin
                s_m   = 32'h0000_0001;
                s_act = 1'b1;
            end else if (s_val && s_act) begin
                for (int i = 0; i < BN; i++) s_m = mdl_byte(s_m, 8'hFF);
                s_q.push_back({s_m, s_lst});
                if (s_lst) s_act = 1'b0;
            end
        end

        always @(negedge clk) begin
            if (rstn && s_vo) begin
                if (s_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL stress%0d unexpected val_o: dat_o %h", BN, s_dato);
                end else begin
                    s_e = s_q.pop_front();
                    chk($sformatf("stress%0d dat_o", BN), s_dato, s_e.dat);
                    chk($sformatf("stress%0d done_o", BN), 32'(s_done), 32'(s_e.done));
                    chk($sformatf("stress%0d s1 range", BN), 32'(s_dato[15:0] < 16'd65521), 32'd1);
                    chk($sformatf("stress%0d s2 range", BN), 32'(s_dato[31:16] < 16'd65521), 32'd1);
                end
            end
        end

        initial begin
            wait (go_stress);
            @(posedge clk);
            #1;
            s_start = 1'b1;
            @(posedge clk);
            #1;
            s_start = 1'b0;
            for (int b = 0; b < 10000 / BN; b++) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                s_val = 1'b1;
                s_lst = (b == 10000 / BN - 1);
                @(posedge clk);
                #1;
                s_val = 1'b0;
                s_lst = 1'b0;
            end
            repeat (3) @(posedge clk);
            chk($sformatf("stress%0d queue drained", BN), 32'(s_q.size()), 32'd0);
            fin = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t        vt[7];
        logic [31:0] fin;
        logic [31:0] hold;
        int          nb;
        int          run;
        int          cyc;

        vt[0] = '{32'h0000_0001, 96'd0,                  0, 32'h0000_0001};
        vt[1] = '{32'h0000_0001, {24'd0, "Wikipedia"},   9, 32'h11E6_0398};
        vt[2] = '{32'h0000_0001, {64'd0, "Wiki"},        4, 32'h03DA_0195};
        vt[3] = '{32'h03DA_0195, {56'd0, "pedia"},       5, 32'h11E6_0398};
        vt[4] = '{32'h0000_0001, {72'd0, "abc"},         3, 32'h024D_0127};
        vt[5] = '{32'hFFFF_FFFF, {88'd0, "a"},           1, 32'h007D_006F};
        vt[6] = '{32'hFFF1_FFF1, 96'd0,                  0, 32'h0000_0000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset rdy_o", 32'(rdy_o), 32'd0);
        chk("reset val_o", 32'(val_o), 32'd0);
        chk("reset done_o", 32'(done_o), 32'd0);
        chk("reset dat_o", dat_o, 32'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int t = 0; t < 7; t++) begin
            run_stream(vt[t].seed, vt[t].data, vt[t].n, fin, nb, run);
            chk($sformatf("vec%0d final", t), fin, vt[t].exp);
            chk($sformatf("vec%0d val_o run", t), 32'(run), 32'(nb));
            repeat (2) @(posedge clk);
            #1;
        end

        // cnt_i above BYTE_NUM is clamped.
        do_start(32'h0000_0001);
        val_i = 1'b1;
        dat_i = "Wiki";
        lst_i = 1'b1;
        cnt_i = 3'd7;
        @(posedge clk);
        #1;
        val_i = 1'b0;
        lst_i = 1'b0;
        wait_done(fin, run);
        chk("cnt clamp final", fin, 32'h03DA_0195);

        // val_i while idle has no effect.
        hold  = dat_o;
        val_i = 1'b1;
        dat_i = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        chk("idle val_o", 32'(val_o), 32'd0);
        chk("idle dat_o hold", dat_o, hold);
        val_i = 1'b0;

        // Restart in the done cycle, then start colliding with a beat.
        do_start(32'h0000_0001);
        val_i = 1'b1;
        dat_i = "Wiki";
        lst_i = 1'b1;
        cnt_i = 3'd4;
        @(posedge clk);
        #1;
        chk("restart done cycle", 32'(done_o), 32'd1);
        start_i = 1'b1;
        seed_i  = 32'h0005_0007;
        dat_i   = "pedi";
        lst_i   = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("restart rdy_o", 32'(rdy_o), 32'd1);
        chk("restart dat_o", dat_o, 32'h0005_0007);
        @(posedge clk);
        #1;
        chk("beat after restart val_o", 32'(val_o), 32'd1);
        start_i = 1'b1;
        seed_i  = 32'h0009_0002;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("collision val_o", 32'(val_o), 32'd0);
        chk("collision dat_o", dat_o, 32'h0009_0002);
        lst_i = 1'b1;
        cnt_i = 3'd0;
        @(posedge clk);
        #1;
        val_i = 1'b0;
        lst_i = 1'b0;
        wait_done(fin, run);
        chk("collision final", fin, 32'h0009_0002);

        // Reset in the middle of a stream.
        do_start(32'h0001_0002);
        val_i = 1'b1;
        dat_i = "Wiki";
        lst_i = 1'b0;
        @(posedge clk);
        #1;
        rstn  = 1'b0;
        val_i = 1'b0;
        #1;
        chk("midreset rdy_o", 32'(rdy_o), 32'd0);
        chk("midreset val_o", 32'(val_o), 32'd0);
        chk("midreset done_o", 32'(done_o), 32'd0);
        chk("midreset dat_o", dat_o, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post-reset val_o", 32'(val_o), 32'd0);
        chk("post-reset dat_o", dat_o, 32'd0);
        do_start(32'h0000_0001);
        chk("post-reset start dat_o", dat_o, 32'h0000_0001);
        val_i = 1'b1;
        lst_i = 1'b1;
        cnt_i = 3'd0;
        @(posedge clk);
        #1;
        val_i = 1'b0;
        lst_i = 1'b0;
        wait_done(fin, run);
        chk("post-reset empty final", fin, 32'h0000_0001);
        repeat (2) @(posedge clk);
        chk("main queue drained", 32'(q.size()), 32'd0);

        go_stress = 1'b1;
        cyc = 0;
        while (!(g_st[0].fin && g_st[1].fin && g_st[2].fin && g_st[3].fin) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 60000) begin
            n_checks++;
            n_errors++;
            $display("FAIL stress timeout: got %0d cycles expected completion", cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adler32_par.md
# adler32_par

Parametrised Adler-32 engine that folds BYTE_NUM bytes per clock, replacing the one-byte-per-cycle checksum block in the zlib stream wrapper of the PNG encoder. It accepts a beat every cycle under a valid/ready handshake and supports a partial final beat. It can be seeded with a prior checksum, so split IDAT streams can be continued without recomputation. It sits beside the deflate core, tapping the uncompressed byte stream, and feeds the zlib trailer writer.

## Interface
- BYTE_NUM, 4, bytes per beat; legal values 1, 2, 4, 8.
- CNT_WD, $clog2(BYTE_NUM)+1, width of cnt_i.
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start_i  in  1  begin (or restart) a checksum; loads seed_i.
- seed_i  in  32  initial {s2,s1}; use 32'h0000_0001 for a fresh stream.
- val_i  in  1  input beat valid.
- rdy_o  out  1  block can accept a beat.
- dat_i  in  8*BYTE_NUM  data; byte 0 = dat_i[8*BYTE_NUM-1 -: 8] (MSB first), byte BYTE_NUM-1 = dat_i[7:0].
- lst_i  in  1  beat is last of stream.
- cnt_i  in  CNT_WD  valid bytes on last beat, 0..BYTE_NUM; ignored when lst_i=0.
- val_o  out  1  one-cycle pulse: dat_o updated for an accepted beat.
- done_o  out  1  one-cycle pulse: dat_o holds final checksum.
- dat_o  out  32  registered {s2[15:0], s1[15:0]}.

## Operation
- FSM has two states, IDLE and ACTV.
- **IDLE**
  - rdy_o=0.
  - start_i -> ACTV; load s1 = seed_i[15:0] and s2 = seed_i[31:16].
  - On load, each half ≥ 65521 has 65521 subtracted once.
  - val_i in IDLE is ignored.
- **ACTV**
  - rdy_o=1. A beat is accepted when val_i && rdy_o.
  - Accepted beat with lst_i=0 -> stay in ACTV; k = BYTE_NUM.
  - Accepted beat with lst_i=1 -> IDLE; k = cnt_i, with values > BYTE_NUM clamped to BYTE_NUM.
  - start_i in ACTV re-seeds (abort/restart) and takes priority over a same-cycle beat, which is dropped with no val_o.
- **Update for k active bytes d0..d(k-1)**
  - s1' = (s1 + Σ d_i) mod 65521.
  - s2' = (s2 + k·s1 + Σ_{i<k} (k−i)·d_i) mod 65521.
  - Bytes k..BYTE_NUM-1 do not contribute.
  - k=0 leaves s1 and s2 unchanged but still produces val_o and done_o.
- **Widths and reduction**
  - s1 sum: 17 bits; at most one conditional subtract of 65521.
  - s2 sum: up to 20 bits for BYTE_NUM=8, max 598860.
  - s2 is reduced by a compare chain against j·65521, j = 1..BYTE_NUM+1, subtracting the largest j·65521 not exceeding the sum.
  - No divider, no `%` operator.
- The update is single-cycle combinational from registered s1/s2; no internal pipeline.
- dat_o always reflects the current {s2,s1} registers. After start it equals the reduced seed.

## Timing
- **Reset values:** state IDLE, rdy_o=0, val_o=0, done_o=0, dat_o=32'h0000_0000.
- **Start:** start_i in cycle T -> rdy_o=1 and dat_o=seed from T+1.
- **Throughput:** one beat per cycle while in ACTV; val_i may stay high continuously.
- **Latency:** beat accepted at edge T -> dat_o updated and val_o=1 during cycle T+1.
- **Last beat:** accepted at edge T -> val_o=1 and done_o=1 during T+1; rdy_o=0 from T+1.
- **Restart:** a new start_i is allowed in the same cycle done_o is high.
- **Hold:** dat_o holds its value in IDLE until the next start_i.
- **Reset mid-stream:** rstn low at any time returns all outputs to reset values immediately; no pulse is emitted on release.

## Test plan
- **Reset:** assert rstn=0 mid-stream -> rdy_o, val_o, done_o = 0 and dat_o = 0 immediately; first start after release -> dat_o = 32'h0000_0001.
- **Empty stream:** seed 32'h1, BYTE_NUM=4, single beat lst_i=1 cnt_i=0 -> done_o with dat_o = 32'h0000_0001.
- **Partial last beat:** "Wikipedia" as beats "Wiki", "pedi", "a" (cnt_i=1), back-to-back -> val_o on 3 consecutive cycles; final dat_o = 32'h11E6_0398.
- **Seeded continuation:**
  - "Wiki" alone -> 32'h03DA_0195.
  - Restart with seed_i = 32'h03DA_0195, send "pedi", "a" -> 32'h11E6_0398.
- **Modulo stress:** 10000 bytes of 8'hFF at BYTE_NUM = 1, 2, 4, 8 with random val_i gaps -> dat_o matches the software model on every val_o; s1 and s2 never reach ≥ 65521.
- **Collisions:**
  - start_i with val_i in ACTV -> beat dropped, no val_o, dat_o = new seed.
  - val_i in IDLE -> no effect.
  - cnt_i = 7 at BYTE_NUM=4 -> treated as 4.
